fetch_request_unit: RTL and testbench

- Upstream neighbour of the single-cycle control unit. Owns the program counter and computes next-PC from the decoded control (PcSrc/JReg/JType/Halt).
- Latches data-memory read/write requests until the cache reports dHit.
- Gates instruction fetch and PC advance so that one instruction retires per completed access sequence.
- Feeds pc to instruction memory and pc_plus4 to the JAL link path; consumes control unit outputs.

---
 rtl/fetch_request_unit.sv | 102 ++++++++++
 tb/tb_fetch_request_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_request_unit.sv
// Program counter owner and fetch/data-request sequencer: computes next-PC from decoded
// control, holds data-memory requests until dHit, and stops fetching once HALT retires.
module fetch_request_unit #(
    parameter int unsigned         WORD_W  = 32,
    parameter logic [WORD_W-1:0]   PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iHit,
    input  logic              dHit,
    input  logic              PcSrc,
    input  logic              JReg,
    input  logic              JType,
    input  logic              Halt,
    input  logic              dMemRe,
    input  logic              dMemWr,
    input  logic [15:0]       imm16,
    input  logic [25:0]       jaddr26,
    input  logic [WORD_W-1:0] rdat1,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              halt
);

    logic [WORD_W-1:0] pc_q, pc_d;
    logic              dren_q, dren_d;
    logic              dwen_q, dwen_d;
    logic              halt_q, halt_d;

    logic              dpend;
    logic [WORD_W-1:0] br_off;
    logic [WORD_W-1:0] next_pc;

    // Jump selection is fully decoded by {JReg,PcSrc}; JType carries no extra information.
    logic unused_jtype;
    assign unused_jtype = JType;

    assign dpend    = dren_q | dwen_q;
    assign pc_plus4 = pc_q + WORD_W'(4);
    assign br_off   = {{(WORD_W-18){imm16[15]}}, imm16, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        unique case ({JReg, PcSrc})
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = pc_plus4 + br_off;
            2'b11: next_pc = {pc_plus4[WORD_W-1 -: WORD_W-28], jaddr26, 2'b00};
            2'b10: next_pc = rdat1;
            default: next_pc = pc_plus4;
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        dren_d = dren_q;
        dwen_d = dwen_q;
        halt_d = halt_q;
        if (!halt_q) begin
            if (dpend) begin
                // Control inputs still describe the held load/store, so it retires here.
                if (dHit) begin
                    dren_d = 1'b0;
                    dwen_d = 1'b0;
                    pc_d   = next_pc;
                end
            end else if (iHit) begin
                if (Halt) begin
                    halt_d = 1'b1;
                end else if (dMemRe || dMemWr) begin
                    dren_d = dMemRe;
                    dwen_d = dMemWr;
                end else begin
                    pc_d = next_pc;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q   <= PC_INIT;
            dren_q <= 1'b0;
            dwen_q <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            dren_q <= dren_d;
            dwen_q <= dwen_d;
            halt_q <= halt_d;
        end
    end

    assign pc   = pc_q;
    assign dREN = dren_q;
    assign dWEN = dwen_q;
    assign halt = halt_q;
    assign iREN = ~dpend & ~halt_q;

endmodule

// File: tb/tb_fetch_request_unit.sv
// Directed bench for fetch_request_unit: a behavioural next-state model checked every cycle,
// plus literal expectations along the directed sequence.
module tb_fetch_request_unit;

    localparam logic [31:0] PcInit = 32'h0000_0100;

    logic        CLK, nRST;
    logic        iHit, dHit, PcSrc, JReg, JType, ctl_halt, dMemRe, dMemWr;
    logic [15:0] imm16;
    logic [25:0] jaddr26;
    logic [31:0] rdat1;
    logic [31:0] pc, pc_plus4;
    logic        iREN, dREN, dWEN, halted;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_request_unit #(
        .WORD_W (32),
        .PC_INIT(PcInit)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iHit    (iHit),
        .dHit    (dHit),
        .PcSrc   (PcSrc),
        .JReg    (JReg),
        .JType   (JType),
        .Halt    (ctl_halt),
        .dMemRe  (dMemRe),
        .dMemWr  (dMemWr),
        .imm16   (imm16),
        .jaddr26 (jaddr26),
        .rdat1   (rdat1),
        .pc      (pc),
        .pc_plus4(pc_plus4),
        .iREN    (iREN),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .halt    (halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural model: architectural state only, advanced by the sequencing rules.
    logic [31:0] m_pc;
    logic        m_rd, m_wr, m_halt;

    function automatic logic [31:0] target(input logic [1:0] sel, input logic [31:0] cur,
                                           input logic [15:0] im, input logic [25:0] ja,
                                           input logic [31:0] rd);
        logic [31:0] seq;
        seq = cur + 32'd4;
        case (sel)
            2'b01:   return seq + (32'($signed(im)) << 2);
            2'b11:   return (seq & 32'hF000_0000) | (32'(ja) << 2);
            2'b10:   return rd;
            default: return seq;
        endcase
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_pc   <= PcInit;
            m_rd   <= 1'b0;
            m_wr   <= 1'b0;
            m_halt <= 1'b0;
        end else if (m_halt) begin
            m_pc <= m_pc;
        end else if (m_rd || m_wr) begin
            if (dHit) begin
                m_rd <= 1'b0;
                m_wr <= 1'b0;
                m_pc <= target({JReg, PcSrc}, m_pc, imm16, jaddr26, rdat1);
            end
        end else if (iHit) begin
            if (ctl_halt) m_halt <= 1'b1;
            else if (dMemRe || dMemWr) begin
                m_rd <= dMemRe;
                m_wr <= dMemWr;
            end else m_pc <= target({JReg, PcSrc}, m_pc, imm16, jaddr26, rdat1);
        end
    end

    always @(posedge CLK) begin
        if (nRST && iREN && iHit && !ctl_halt)
            assert (!(dMemRe && dMemWr)) else $error("illegal decode: dMemRe and dMemWr both high");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge CLK) begin
        if (nRST) begin
            chk("model pc", pc, m_pc);
            chk("model pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("model iREN", 32'(iREN), 32'(!(m_rd || m_wr) && !m_halt));
            chk("model dREN", 32'(dREN), 32'(m_rd));
            chk("model dWEN", 32'(dWEN), 32'(m_wr));
            chk("model halt", 32'(halted), 32'(m_halt));
        end
    end

    // Drive one cycle's inputs just after a falling edge, return after the next falling edge.
    task automatic cyc(input logic ih, input logic dh, input logic [1:0] sel, input logic hl,
                       input logic re, input logic wr, input logic [15:0] im,
                       input logic [25:0] ja, input logic [31:0] rd);
        iHit     = ih;
        dHit     = dh;
        JReg     = sel[1];
        PcSrc    = sel[0];
        JType    = (sel == 2'b11);
        ctl_halt = hl;
        dMemRe   = re;
        dMemWr   = wr;
        imm16    = im;
        jaddr26  = ja;
        rdat1    = rd;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic jr(input logic [31:0] addr);
        cyc(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, addr);
    endtask

    initial begin
        nRST = 1'b0;
        iHit = 0; dHit = 0; PcSrc = 0; JReg = 0; JType = 0; ctl_halt = 0;
        dMemRe = 0; dMemWr = 0; imm16 = '0; jaddr26 = '0; rdat1 = '0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk("reset pc", pc, 32'h100);
        chk("reset iREN", 32'(iREN), 32'd1);
        chk("reset dREN", 32'(dREN), 32'd0);
        chk("reset halt", 32'(halted), 32'd0);

        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
            chk("seq pc", pc, 32'h100 + 32'(4 * i));
            chk("seq iREN", 32'(iREN), 32'd1);
        end

        jr(32'h200);
        chk("jr 0x200", pc, 32'h200);
        cyc(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 16'hFFFE, 26'h0, 32'h0);
        chk("beq back", pc, 32'h1FC);
        jr(32'h200);
        cyc(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0003, 26'h0, 32'h0);
        chk("beq fwd", pc, 32'h210);

        jr(32'h3000_0010);
        cyc(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0000040, 32'h0);
        chk("j target", pc, 32'h3000_0100);
        jr(32'hDEAD_BEE0);
        chk("jr dead", pc, 32'hDEAD_BEE0);
        jr(32'hFFFF_FFFC);
        chk("pc_plus4 wrap", pc_plus4, 32'h0);

        // Load: request, stall with iHit noise, then retire on dHit.
        jr(32'h40);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
        chk("lw dREN", 32'(dREN), 32'd1);
        chk("lw pc hold", pc, 32'h40);
        chk("lw iREN", 32'(iREN), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'(i), 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
            chk("lw stall pc", pc, 32'h40);
        end
        cyc(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
        chk("lw done dREN", 32'(dREN), 32'd0);
        chk("lw done pc", pc, 32'h44);
        cyc(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        chk("stray dHit pc", pc, 32'h44);

        cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0);
        chk("sw dWEN", 32'(dWEN), 32'd1);
        chk("sw pc hold", pc, 32'h44);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0);
        cyc(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0);
        chk("sw done dWEN", 32'(dWEN), 32'd0);
        chk("sw done pc", pc, 32'h48);

        // HALT with a load decoded alongside: halt wins, no request.
        jr(32'h80);
        cyc(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
        chk("halt set", 32'(halted), 32'd1);
        chk("halt iREN", 32'(iREN), 32'd0);
        chk("halt no dREN", 32'(dREN), 32'd0);
        for (int i = 0; i < 10; i++)
            cyc(1'(i), 1'(i + 1), 2'(i), 1'(i >> 1), 1'(i >> 2), 1'b0, 16'h1, 26'h3, 32'h500);
        chk("halt pc frozen", pc, 32'h80);

        nRST = 1'b0;
        #1;
        chk("reset clears halt", 32'(halted), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // Store pending, then reset in the middle of the low phase.
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0);
        chk("sw2 dWEN", 32'(dWEN), 32'd1);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0);
        #2 nRST = 1'b0;
        #1;
        chk("async dWEN", 32'(dWEN), 32'd0);
        chk("async pc", pc, PcInit);
        chk("async halt", 32'(halted), 32'd0);
        chk("async iREN", 32'(iREN), 32'd1);
        @(negedge CLK);
        nRST = 1'b1;
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        chk("post reset seq", pc, 32'h104);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
